// File: rtl/axi_sync_chan_buffer.sv
// Single-clock multi-channel AXI channel buffer.
// One independent FWFT FIFO per channel with occupancy and almost-full.
module axi_sync_chan_buffer #(
  parameter int NUM_CH    = 5,
  parameter int DATA_W    = 45,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic                     axi_clk,
  input  logic                     axi_rst,
  input  logic [NUM_CH-1:0]        s_valid,
  output logic [NUM_CH-1:0]        s_ready,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  output logic [NUM_CH-1:0]        m_valid,
  input  logic [NUM_CH-1:0]        m_ready,
  output logic [NUM_CH*DATA_W-1:0] m_data,
  input  logic [NUM_CH-1:0]        flush,
  output logic [NUM_CH*LW-1:0]     level,
  output logic [NUM_CH-1:0]        almost_full
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [LW-1:0]     wr;
    logic [LW-1:0]     rd;
    logic [LW-1:0]     lvl;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Extra pointer MSB tells full from empty when indices match
    assign full  = (wr ^ rd) == {1'b1, {PW{1'b0}}};
    assign empty = wr == rd;

    assign s_ready[i] = !full && !flush[i] && !axi_rst;
    assign m_valid[i] = !empty;
    assign push = s_valid[i] && s_ready[i];
    assign pop  = m_valid[i] && m_ready[i] && !flush[i];

    assign m_data[i*DATA_W +: DATA_W] = mem[rd[PW-1:0]];
    assign level[i*LW +: LW]          = lvl;
    assign almost_full[i]             = lvl >= LW'(AF_THRESH);

    always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
        wr  <= '0;
        rd  <= '0;
        lvl <= '0;
      end else if (flush[i]) begin
        wr  <= '0;
        rd  <= '0;
        lvl <= '0;
      end else begin
        if (push) wr <= wr + 1'b1;
        if (pop)  rd <= rd + 1'b1;
        case ({push, pop})
          2'b10:   lvl <= lvl + 1'b1;
          2'b01:   lvl <= lvl - 1'b1;
          default: lvl <= lvl;
        endcase
      end
    end

    always_ff @(posedge axi_clk) begin
      if (push) mem[wr[PW-1:0]] <= s_data[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_axi_sync_chan_buffer.sv
// Directed bench for axi_sync_chan_buffer.
// Table-driven single-channel vectors plus wrap, flush-isolation and reset sequences.
module tb_axi_sync_chan_buffer;
  localparam int NC = 5;
  localparam int DW = 45;
  localparam int LW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    s_valid;
  logic [NC-1:0]    s_ready;
  logic [NC*DW-1:0] s_data;
  logic [NC-1:0]    m_valid;
  logic [NC-1:0]    m_ready;
  logic [NC*DW-1:0] m_data;
  logic [NC-1:0]    flush;
  logic [NC*LW-1:0] level;
  logic [NC-1:0]    almost_full;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_sync_chan_buffer #(
    .NUM_CH(NC), .DATA_W(DW), .DEPTH(4), .AF_THRESH(3)
  ) dut (
    .axi_clk(clk),
    .axi_rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .flush(flush),
    .level(level),
    .almost_full(almost_full)
  );

  typedef struct {
    int          ch;
    logic        sv;
    logic [44:0] d;
    logic        mr;
    logic        fl;
    logic        e_sr;
    logic        e_mv;
    logic        dchk;
    logic [44:0] e_md;
    logic [2:0]  e_lv;
    logic        e_af;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int ch, logic sv, logic [44:0] d, logic mr,
                              logic fl, logic sr, logic mv, logic dc,
                              logic [44:0] md, logic [2:0] lv, logic af);
    vec_t v;
    v.ch = ch; v.sv = sv; v.d = d; v.mr = mr; v.fl = fl;
    v.e_sr = sr; v.e_mv = mv; v.dchk = dc; v.e_md = md;
    v.e_lv = lv; v.e_af = af;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    s_valid = '0;
    m_ready = '0;
    flush   = '0;
    s_data  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] lv(int ch);
    return level[ch*LW +: LW];
  endfunction

  function automatic logic [44:0] md(int ch);
    return m_data[ch*DW +: DW];
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    step();
    chk("rst_sready", 64'(s_ready), 64'h0);
    step();
    chk("rst_mvalid", 64'(m_valid), 64'h0);
    chk("rst_level", 64'(level), 64'h0);
    chk("rst_af", 64'(almost_full), 64'h0);
    rst = 1'b0;
    #1;
    chk("rel_sready", 64'(s_ready), 64'h1f);

    // ch0 fill to full, held fifth push, drain in order
    tbl.push_back(mk(0, 1, 45'h1, 0, 0, 1, 0, 0, 45'h0, 0, 0));
    tbl.push_back(mk(0, 1, 45'h2, 0, 0, 1, 1, 1, 45'h1, 1, 0));
    tbl.push_back(mk(0, 1, 45'h3, 0, 0, 1, 1, 1, 45'h1, 2, 0));
    tbl.push_back(mk(0, 1, 45'h4, 0, 0, 1, 1, 1, 45'h1, 3, 1));
    tbl.push_back(mk(0, 1, 45'h5, 0, 0, 0, 1, 1, 45'h1, 4, 1));
    tbl.push_back(mk(0, 0, 45'h0, 1, 0, 0, 1, 1, 45'h1, 4, 1));
    tbl.push_back(mk(0, 0, 45'h0, 1, 0, 1, 1, 1, 45'h2, 3, 1));
    tbl.push_back(mk(0, 0, 45'h0, 1, 0, 1, 1, 1, 45'h3, 2, 0));
    tbl.push_back(mk(0, 0, 45'h0, 1, 0, 1, 1, 1, 45'h4, 1, 0));
    tbl.push_back(mk(0, 0, 45'h0, 0, 0, 1, 0, 0, 45'h0, 0, 0));
    // ch1 steady push+pop at level 2
    tbl.push_back(mk(1, 1, 45'hA, 0, 0, 1, 0, 0, 45'h0, 0, 0));
    tbl.push_back(mk(1, 1, 45'hB, 0, 0, 1, 1, 1, 45'hA, 1, 0));
    tbl.push_back(mk(1, 1, 45'hC, 1, 0, 1, 1, 1, 45'hA, 2, 0));
    tbl.push_back(mk(1, 1, 45'hD, 1, 0, 1, 1, 1, 45'hB, 2, 0));
    tbl.push_back(mk(1, 0, 45'h0, 1, 0, 1, 1, 1, 45'hC, 2, 0));
    tbl.push_back(mk(1, 0, 45'h0, 1, 0, 1, 1, 1, 45'hD, 1, 0));
    tbl.push_back(mk(1, 0, 45'h0, 0, 0, 1, 0, 0, 45'h0, 0, 0));
    // ch3 flush at level 3 with coincident push and pop
    tbl.push_back(mk(3, 1, 45'h31, 0, 0, 1, 0, 0, 45'h0, 0, 0));
    tbl.push_back(mk(3, 1, 45'h32, 0, 0, 1, 1, 1, 45'h31, 1, 0));
    tbl.push_back(mk(3, 1, 45'h33, 0, 0, 1, 1, 1, 45'h31, 2, 0));
    tbl.push_back(mk(3, 1, 45'h34, 1, 1, 0, 1, 1, 45'h31, 3, 1));
    tbl.push_back(mk(3, 0, 45'h0, 0, 0, 1, 0, 0, 45'h0, 0, 0));
    tbl.push_back(mk(3, 1, 45'h35, 0, 0, 1, 0, 0, 45'h0, 0, 0));
    tbl.push_back(mk(3, 0, 45'h0, 1, 0, 1, 1, 1, 45'h35, 1, 0));
    tbl.push_back(mk(3, 0, 45'h0, 0, 0, 1, 0, 0, 45'h0, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      vec_t v;
      v = tbl[k];
      idle();
      s_valid[v.ch]            = v.sv;
      s_data[v.ch*DW +: DW]    = v.d;
      m_ready[v.ch]            = v.mr;
      flush[v.ch]              = v.fl;
      #1;
      chk($sformatf("v%0d_sready", k), 64'(s_ready[v.ch]), 64'(v.e_sr));
      chk($sformatf("v%0d_mvalid", k), 64'(m_valid[v.ch]), 64'(v.e_mv));
      chk($sformatf("v%0d_level", k), 64'(lv(v.ch)), 64'(v.e_lv));
      chk($sformatf("v%0d_af", k), 64'(almost_full[v.ch]), 64'(v.e_af));
      if (v.dchk)
        chk($sformatf("v%0d_mdata", k), 64'(md(v.ch)), 64'(v.e_md));
      step();
    end

    // ch2 wrap: 10 rounds of push-3/pop-3
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) begin
        idle();
        s_valid[2] = 1'b1;
        s_data[2*DW +: DW] = 45'(r*3 + k);
        step();
      end
      for (int k = 0; k < 3; k++) begin
        idle();
        m_ready[2] = 1'b1;
        #1;
        chk($sformatf("wrap_mvalid_%0d", r*3+k), 64'(m_valid[2]), 64'h1);
        chk($sformatf("wrap_mdata_%0d", r*3+k), 64'(md(2)), 64'(r*3 + k));
        step();
      end
    end
    idle();
    #1;
    chk("wrap_end_level", 64'(lv(2)), 64'h0);

    // All channels to level 2, flush ch3 only
    for (int k = 0; k < 2; k++) begin
      idle();
      s_valid = '1;
      for (int c = 0; c < NC; c++) s_data[c*DW +: DW] = 45'('h100 + c*16 + k);
      step();
    end
    idle();
    flush[3] = 1'b1;
    step();
    idle();
    #1;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("fl_level_%0d", c), 64'(lv(c)), (c == 3) ? 64'h0 : 64'h2);
      chk($sformatf("fl_mvalid_%0d", c), 64'(m_valid[c]), (c == 3) ? 64'h0 : 64'h1);
      if (c != 3) chk($sformatf("fl_mdata_%0d", c), 64'(md(c)), 64'('h100 + c*16));
    end
    for (int k = 0; k < 2; k++) begin
      idle();
      s_valid[3] = 1'b1;
      s_data[3*DW +: DW] = 45'('h200 + k);
      step();
    end
    idle();
    #1;
    chk("pre_rst_level", 64'(level), 64'({5{3'd2}}));

    // Reset with all channels at level 2
    rst = 1'b1;
    s_valid = '1;
    #1;
    chk("mid_rst_sready", 64'(s_ready), 64'h0);
    step();
    rst = 1'b0;
    idle();
    #1;
    chk("post_rst_level", 64'(level), 64'h0);
    chk("post_rst_mvalid", 64'(m_valid), 64'h0);
    chk("post_rst_sready", 64'(s_ready), 64'h1f);
    chk("post_rst_af", 64'(almost_full), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
